// File: rtl/cpu_pkg.sv
// Shared encodings for the MIPS pipeline: opcode/funct constants, the ALU
// operation enum and the decoded control bundle carried into execute.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    beq;
    logic    bne;
    logic    jump;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 2**REG_AW x DATA_W register file: two combinational read ports with
// write-through bypass, one write port, r0 hardwired to zero.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // A write landing this edge is forwarded so decode never captures the stale value.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && (wa == ra1)) ? wd : mem[ra1];
    if (ra2 != '0) rd2 = (we && (wa == ra2)) ? wd : mem[ra2];
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: control decode, register read, immediate extension and the
// decode/execute pipeline register, plus the jump redirect back to fetch.
module instruction_decode
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       IF_PC,
  input  logic [31:0]       IF_IR,
  input  logic              flush,
  input  logic              WB_RegWrite,
  input  logic [REG_AW-1:0] WB_WriteReg,
  input  logic [DATA_W-1:0] WB_WriteData,
  output logic [31:0]       DF_PC,
  output logic [DATA_W-1:0] DF_RsData,
  output logic [DATA_W-1:0] DF_RtData,
  output logic [31:0]       DF_Imm,
  output logic [REG_AW-1:0] DF_WriteReg,
  output logic [2:0]        DF_ALUOp,
  output logic              DF_ALUSrc,
  output logic              DF_RegWrite,
  output logic              DF_MemRead,
  output logic              DF_MemWrite,
  output logic              DF_MemToReg,
  output logic              DF_Beqctr,
  output logic              DF_Bnectr,
  output logic              DF_Jumpctr,
  output logic [31:0]       DF_JumpImm,
  output logic              DF_Illegal
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [31:0]       imm_ext;
  logic [31:0]       jump_imm;
  ctrl_t             dec;
  logic [REG_AW-1:0] wr_reg;

  assign opcode   = IF_IR[31:26];
  assign rs       = IF_IR[25:21];
  assign rt       = IF_IR[20:16];
  assign rd       = IF_IR[15:11];
  assign funct    = IF_IR[5:0];
  assign imm_ext  = {{16{IF_IR[15]}}, IF_IR[15:0]};
  assign jump_imm = {4'b0000, IF_IR[25:0], 2'b00};

  reg_file #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rs_data),
    .rd2 (rt_data),
    .we  (WB_RegWrite),
    .wa  (WB_WriteReg),
    .wd  (WB_WriteData)
  );

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    wr_reg     = '0;
    case (opcode)
      OP_RTYPE: begin
        wr_reg        = rd;
        dec.reg_write = 1'b1;
        case (funct)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          default: begin
            wr_reg        = '0;
            dec.reg_write = 1'b0;
            dec.illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        wr_reg        = rt;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_LW: begin
        wr_reg         = rt;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_op = ALU_SUB;
        dec.beq    = 1'b1;
      end
      OP_BNE: begin
        dec.alu_op = ALU_SUB;
        dec.bne    = 1'b1;
      end
      OP_J:    dec.jump    = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
    // Writes to r0 are architecturally void, so NOP becomes a pure bubble.
    if (wr_reg == '0) dec.reg_write = 1'b0;
    if (flush) begin
      dec.reg_write  = 1'b0;
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.beq        = 1'b0;
      dec.bne        = 1'b0;
      dec.jump       = 1'b0;
      dec.illegal    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DF_PC       <= '0;
      DF_RsData   <= '0;
      DF_RtData   <= '0;
      DF_Imm      <= '0;
      DF_WriteReg <= '0;
      DF_ALUOp    <= '0;
      DF_ALUSrc   <= 1'b0;
      DF_RegWrite <= 1'b0;
      DF_MemRead  <= 1'b0;
      DF_MemWrite <= 1'b0;
      DF_MemToReg <= 1'b0;
      DF_Beqctr   <= 1'b0;
      DF_Bnectr   <= 1'b0;
      DF_Jumpctr  <= 1'b0;
      DF_JumpImm  <= '0;
      DF_Illegal  <= 1'b0;
    end else begin
      DF_PC       <= IF_PC;
      DF_RsData   <= rs_data;
      DF_RtData   <= rt_data;
      DF_Imm      <= imm_ext;
      DF_WriteReg <= wr_reg;
      DF_ALUOp    <= dec.alu_op;
      DF_ALUSrc   <= dec.alu_src;
      DF_RegWrite <= dec.reg_write;
      DF_MemRead  <= dec.mem_read;
      DF_MemWrite <= dec.mem_write;
      DF_MemToReg <= dec.mem_to_reg;
      DF_Beqctr   <= dec.beq;
      DF_Bnectr   <= dec.bne;
      DF_Jumpctr  <= dec.jump;
      DF_JumpImm  <= jump_imm;
      DF_Illegal  <= dec.illegal;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed scenarios followed by
// randomized instruction/writeback/flush traffic against a behavioural model.
module tb_instruction_decode;

  logic        clk;
  logic        rst;
  logic [31:0] IF_PC;
  logic [31:0] IF_IR;
  logic        flush;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic [31:0] DF_PC;
  logic [31:0] DF_RsData;
  logic [31:0] DF_RtData;
  logic [31:0] DF_Imm;
  logic [4:0]  DF_WriteReg;
  logic [2:0]  DF_ALUOp;
  logic        DF_ALUSrc;
  logic        DF_RegWrite;
  logic        DF_MemRead;
  logic        DF_MemWrite;
  logic        DF_MemToReg;
  logic        DF_Beqctr;
  logic        DF_Bnectr;
  logic        DF_Jumpctr;
  logic [31:0] DF_JumpImm;
  logic        DF_Illegal;

  instruction_decode dut (
    .clk          (clk),
    .rst          (rst),
    .IF_PC        (IF_PC),
    .IF_IR        (IF_IR),
    .flush        (flush),
    .WB_RegWrite  (WB_RegWrite),
    .WB_WriteReg  (WB_WriteReg),
    .WB_WriteData (WB_WriteData),
    .DF_PC        (DF_PC),
    .DF_RsData    (DF_RsData),
    .DF_RtData    (DF_RtData),
    .DF_Imm       (DF_Imm),
    .DF_WriteReg  (DF_WriteReg),
    .DF_ALUOp     (DF_ALUOp),
    .DF_ALUSrc    (DF_ALUSrc),
    .DF_RegWrite  (DF_RegWrite),
    .DF_MemRead   (DF_MemRead),
    .DF_MemWrite  (DF_MemWrite),
    .DF_MemToReg  (DF_MemToReg),
    .DF_Beqctr    (DF_Beqctr),
    .DF_Bnectr    (DF_Bnectr),
    .DF_Jumpctr   (DF_Jumpctr),
    .DF_JumpImm   (DF_JumpImm),
    .DF_Illegal   (DF_Illegal)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // behavioural model state
  logic [31:0] regs [32];
  logic [31:0] e_pc, e_rs, e_rt, e_imm, e_jimm;
  logic [4:0]  e_wr;
  logic [2:0]  e_alu;
  logic        e_src, e_rw, e_mr, e_mw, e_m2r, e_beq, e_bne, e_j, e_ill;
  logic        e_has_dest, e_flush;

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (WB_RegWrite && WB_WriteReg == a) return WB_WriteData;
    return regs[a];
  endfunction

  // ALU codes: add 0, sub 1, and 2, or 3, slt 4
  task automatic model_expect();
    logic [5:0] op, fn;
    op = IF_IR[31:26];
    fn = IF_IR[5:0];
    e_pc  = IF_PC;
    e_rs  = rd_model(IF_IR[25:21]);
    e_rt  = rd_model(IF_IR[20:16]);
    e_imm = {{16{IF_IR[15]}}, IF_IR[15:0]};
    e_jimm = {4'b0, IF_IR[25:0], 2'b00};
    {e_alu, e_src, e_rw, e_mr, e_mw, e_m2r, e_beq, e_bne, e_j, e_ill} = '0;
    e_wr = 0;
    e_has_dest = 1'b0;
    if (op == 6'h00) begin
      e_has_dest = 1'b1;
      e_wr = IF_IR[15:11];
      if      (fn == 6'h20) e_alu = 3'd0;
      else if (fn == 6'h22) e_alu = 3'd1;
      else if (fn == 6'h24) e_alu = 3'd2;
      else if (fn == 6'h25) e_alu = 3'd3;
      else if (fn == 6'h2A) e_alu = 3'd4;
      else begin e_ill = 1'b1; e_has_dest = 1'b0; end
    end else if (op == 6'h08) begin
      e_has_dest = 1'b1; e_wr = IF_IR[20:16]; e_src = 1'b1;
    end else if (op == 6'h23) begin
      e_has_dest = 1'b1; e_wr = IF_IR[20:16]; e_src = 1'b1; e_mr = 1'b1; e_m2r = 1'b1;
    end else if (op == 6'h2B) begin
      e_src = 1'b1; e_mw = 1'b1;
    end else if (op == 6'h04) begin
      e_alu = 3'd1; e_beq = 1'b1;
    end else if (op == 6'h05) begin
      e_alu = 3'd1; e_bne = 1'b1;
    end else if (op == 6'h02) begin
      e_j = 1'b1;
    end else begin
      e_ill = 1'b1;
    end
    e_rw = e_has_dest && (e_wr != 0);
    e_flush = flush;
    if (flush) {e_rw, e_mr, e_mw, e_m2r, e_beq, e_bne, e_j, e_ill} = '0;
  endtask

  task automatic check_all(input string pfx);
    check({pfx, ".pc"},   DF_PC,       e_pc);
    check({pfx, ".rs"},   DF_RsData,   e_rs);
    check({pfx, ".rt"},   DF_RtData,   e_rt);
    check({pfx, ".imm"},  DF_Imm,      e_imm);
    check({pfx, ".jimm"}, DF_JumpImm,  e_jimm);
    check({pfx, ".rw"},   DF_RegWrite, e_rw);
    check({pfx, ".mr"},   DF_MemRead,  e_mr);
    check({pfx, ".mw"},   DF_MemWrite, e_mw);
    check({pfx, ".m2r"},  DF_MemToReg, e_m2r);
    check({pfx, ".beq"},  DF_Beqctr,   e_beq);
    check({pfx, ".bne"},  DF_Bnectr,   e_bne);
    check({pfx, ".j"},    DF_Jumpctr,  e_j);
    check({pfx, ".ill"},  DF_Illegal,  e_ill);
    if (e_has_dest && !e_flush) check({pfx, ".wr"}, DF_WriteReg, e_wr);
    if (!e_flush) begin
      check({pfx, ".alu"}, DF_ALUOp,  e_alu);
      check({pfx, ".src"}, DF_ALUSrc, e_src);
    end
  endtask

  // driver: one decode cycle, model evaluated on pre-edge state
  task automatic step(input string pfx, input logic [31:0] ir, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    IF_PC        = $urandom;
    IF_IR        = ir;
    flush        = fl;
    WB_RegWrite  = we;
    WB_WriteReg  = wa;
    WB_WriteData = wd;
    model_expect();
    @(posedge clk);
    if (we && wa != 0) regs[wa] = wd;
    #1;
    check_all(pfx);
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] s, input logic [4:0] t,
                                       input logic [4:0] d, input logic [5:0] f);
    return {6'h00, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] o, input logic [4:0] s,
                                       input logic [4:0] t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, ".pc"},   DF_PC, 32'h0);
    check({pfx, ".data"}, DF_RsData | DF_RtData | DF_Imm | DF_JumpImm, 32'h0);
    check({pfx, ".ctrl"}, {DF_WriteReg, DF_ALUOp, DF_ALUSrc, DF_RegWrite, DF_MemRead,
                           DF_MemWrite, DF_MemToReg, DF_Beqctr, DF_Bnectr,
                           DF_Jumpctr, DF_Illegal}, 32'h0);
  endtask

  initial begin
    logic [31:0] ir;
    logic [5:0]  fn;
    logic [5:0]  fns [5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    rst = 1'b1;
    IF_PC = 0; IF_IR = 0; flush = 0;
    WB_RegWrite = 0; WB_WriteReg = 0; WB_WriteData = 0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // writeback r1=1, then addi $2,$1,1
    step("wb_r1", 32'h00000020, 0, 1, 5'd1, 32'd1);
    step("addi", 32'h20220001, 0, 0, 0, 0);
    check("addi.rs_const", DF_RsData, 32'd1);
    check("addi.wr_const", DF_WriteReg, 5'd2);
    check("addi.rw_const", DF_RegWrite, 1'b1);

    // bypass: r3 written while add $3,$3,$2 reads it
    step("bypass", mk_r(5'd3, 5'd2, 5'd3, 6'h20), 0, 1, 5'd3, 32'h2A);
    check("bypass.rs_const", DF_RsData, 32'h2A);
    step("r0_wr", 32'h00000020, 0, 1, 5'd0, 32'hFFFF);
    step("r0_rd", mk_r(5'd0, 5'd0, 5'd1, 6'h20), 0, 0, 0, 0);
    check("r0_rd.rs_const", DF_RsData, 32'h0);

    // j 28 then a NOP: single-cycle pulse
    step("jump", 32'h0800001C, 0, 0, 0, 0);
    check("jump.jimm_const", DF_JumpImm, 32'h00000070);
    check("jump.j_const", DF_Jumpctr, 1'b1);
    step("after_j", 32'h00000020, 0, 0, 0, 0);
    check("after_j.j_const", DF_Jumpctr, 1'b0);
    step("bne", mk_i(6'h05, 5'd8, 5'd0, 16'd7), 0, 0, 0, 0);
    check("bne.imm_const", DF_Imm, 32'd7);

    // flushed lw then unflushed lw
    step("lw_flush", mk_i(6'h23, 5'd0, 5'd3, 16'd0), 1, 0, 0, 0);
    step("lw", mk_i(6'h23, 5'd0, 5'd3, 16'd0), 0, 0, 0, 0);
    check("lw.mr_const", {DF_MemRead, DF_MemToReg, DF_RegWrite}, 3'b111);

    // illegal opcode / funct, NOP, negative immediate
    step("ill_op", 32'hFC000000, 0, 0, 0, 0);
    step("ill_fn", mk_r(5'd1, 5'd2, 5'd3, 6'h3F), 0, 0, 0, 0);
    check("ill_fn.ill_const", DF_Illegal, 1'b1);
    step("nop", 32'h00000020, 0, 0, 0, 0);
    check("nop.rw_const", DF_RegWrite, 1'b0);
    step("sw_neg", mk_i(6'h2B, 5'd1, 5'd2, 16'h8000), 0, 0, 0, 0);
    check("sw_neg.imm_const", DF_Imm, 32'hFFFF8000);

    // mid-run async reset with r5 loaded
    step("wb_r5", 32'h00000020, 0, 1, 5'd5, 32'h1234);
    step("rd_r5", mk_r(5'd5, 5'd5, 5'd7, 6'h22), 0, 0, 0, 0);
    check("rd_r5.rs_const", DF_RsData, 32'h1234);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", mk_r(5'd5, 5'd0, 5'd6, 6'h20), 0, 0, 0, 0);
    check("post_rst.rs_const", DF_RsData, 32'h0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 11))
        0, 1:    begin
          fn = fns[$urandom_range(0, 4)];
          ir = mk_r(5'($urandom), 5'($urandom), 5'($urandom), fn);
        end
        2:       ir = mk_i(6'h08, 5'($urandom), 5'($urandom), 16'($urandom));
        3:       ir = mk_i(6'h23, 5'($urandom), 5'($urandom), 16'($urandom));
        4:       ir = mk_i(6'h2B, 5'($urandom), 5'($urandom), 16'($urandom));
        5:       ir = mk_i(6'h04, 5'($urandom), 5'($urandom), 16'($urandom));
        6:       ir = mk_i(6'h05, 5'($urandom), 5'($urandom), 16'($urandom));
        7:       ir = {6'h02, 26'($urandom)};
        8:       ir = mk_r(5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom));
        9:       ir = 32'h00000020;
        default: ir = $urandom;
      endcase
      step("rand", ir, ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
           5'($urandom), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
Second stage of the 5-stage MIPS pipeline. It sits directly downstream of instruction fetch and consumes its registered PC/IR pair.
- Decodes the instruction, reads the 32x32 register file and sign-extends the immediate.
- Registers everything into the decode/execute boundary.
- Drives the jump redirect (DF_Jumpctr/DF_JumpImm) back to fetch, and the beq/bne controls and operands forward to execute.
- The register file write port is driven by the writeback stage.

Parameters:
DATA_W, 32, datapath and register width
REG_AW, 5, register address width (2**REG_AW registers)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
IF_PC  in  32  PC of the instruction in IF_IR
IF_IR  in  32  instruction word from fetch
flush  in  1  insert bubble into the decode/execute register on the next edge
WB_RegWrite  in  1  register file write enable
WB_WriteReg  in  5  write address
WB_WriteData  in  32  write data
DF_PC  out  32  registered IF_PC
DF_RsData  out  32  rs operand
DF_RtData  out  32  rt operand
DF_Imm  out  32  sign-extended IR[15:0]
DF_WriteReg  out  5  destination: rd for R-type, rt for addi/lw
DF_ALUOp  out  3  ALU operation code (package enum)
DF_ALUSrc  out  1  1 = second ALU operand is DF_Imm
DF_RegWrite  out  1  instruction writes a register
DF_MemRead  out  1  lw
DF_MemWrite  out  1  sw
DF_MemToReg  out  1  writeback selects memory data
DF_Beqctr  out  1  beq in execute
DF_Bnectr  out  1  bne in execute
DF_Jumpctr  out  1  j decoded; fetch redirects on next edge
DF_JumpImm  out  32  {4'b0, IR[25:0], 2'b00}
DF_Illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset: all DF_* outputs 0; all 32 registers 0. Async assertion mid-operation clears everything immediately; there is no partial state.
- Latency: IF_IR sampled at posedge N; decoded outputs valid after posedge N (one cycle). Register reads are combinational from IF_IR and captured in the same edge.
- Supported R-type (op 000000), by funct:
  - 0x20 add -> ALU_ADD
  - 0x22 sub -> ALU_SUB
  - 0x24 and -> ALU_AND
  - 0x25 or -> ALU_OR
  - 0x2A slt -> ALU_SLT
- Supported I/J-type:
  - addi 0x08: ALUSrc=1, ALU_ADD, RegWrite, WriteReg=rt
  - lw 0x23: ALUSrc=1, ALU_ADD, MemRead, MemToReg, RegWrite, WriteReg=rt
  - sw 0x2B: ALUSrc=1, ALU_ADD, MemWrite
  - beq 0x04: ALU_SUB, Beqctr
  - bne 0x05: ALU_SUB, Bnectr
  - j 0x02: Jumpctr; no other control set
- Unsupported opcode or R-type funct: every control output 0 (bubble); DF_Illegal=1 for one cycle.
- DF_RegWrite is forced to 0 when the destination is r0, so NOP (0x00000020) decodes as a pure bubble.
- Register file:
  - r0 reads 0 always; writes to r0 are ignored.
  - Write occurs at posedge when WB_RegWrite=1.
  - Same-cycle bypass: if WB_RegWrite=1, WB_WriteReg!=0 and WB_WriteReg equals rs (or rt), the corresponding DF_*Data captures WB_WriteData, not the stale array value.
  - No other hazard detection. Software spacing with NOPs is the contract.
- flush=1 at an edge: all control outputs (RegWrite, MemRead, MemWrite, MemToReg, Beqctr, Bnectr, Jumpctr, Illegal) captured as 0; data outputs still update. flush does not block a register file write in the same cycle.
- DF_Jumpctr is a single-cycle pulse per decoded j. Fetch forms {PC[31:28], DF_JumpImm[27:0]}. The instructions already fetched behind the jump still decode; the program places NOPs there.
- Immediate: DF_Imm = {{16{IR[15]}}, IR[15:0]}. Branch offset scaling is done in execute.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J)
  - funct constants
  - 3-bit ALU op enum (ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SLT=4)
- Sub-module reg_file: 32x32, two combinational read ports, one write port with bypass, r0 hardwired, async reset.
- Control decode stays inline in instruction_decode.

Test Plan:
- Reset mid-run with r5=0x1234 loaded -> all DF_* = 0 immediately; after release, add $6,$5,$0 gives DF_RsData=0.
- WB writes r1=1, then IF_IR=addi $2,$1,1 (0x20220001) -> DF_RsData=1, DF_Imm=1, DF_WriteReg=2, ALUSrc=1, ALU_ADD, RegWrite=1.
- Same-cycle bypass: WB writes r3=0x2A while IF_IR=add $3,$3,$2 -> DF_RsData=0x2A; a write to r0 with 0xFFFF leaves r0 reading 0.
- IF_IR=j 28 (0x0800001C) -> DF_Jumpctr=1 for exactly one cycle, DF_JumpImm=0x00000070; bne $8,$0,7 -> Bnectr=1, DF_Imm=7.
- IF_IR=lw $3,0($0) with flush=1 -> all controls 0; next cycle with flush=0 -> MemRead=MemToReg=RegWrite=1, WriteReg=3.
- IF_IR opcode 0x3F, or R-type funct 0x3F -> DF_Illegal=1 and all controls 0; IF_IR=0x00000020 -> DF_RegWrite=0, DF_Illegal=0.
